sram_access_arbiter: RTL and testbench

//  Shares one internally instantiated sram_1r1w between NUM_REQUESTERS clients.

---
 rtl/sram_access_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sram_access_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_1r1w
// Purpose  : Simple dual-port SRAM, one synchronous read port and one
//            synchronous write port. Contents are not cleared by reset.
//            With READ_DURING_WRITE = "NEW_DATA" a read of the address being
//            written in the same cycle returns the new write data.
// Ports    : clk                          clock
//            read_en / read_addr          read request, data valid next cycle
//            read_data                    registered read data
//            write_en / write_addr / write_data   write request
// Revision : 1.0  initial release
// ============================================================================
module sram_1r1w #(
  parameter int    DATA_WIDTH        = 32,
  parameter int    SIZE              = 1024,
  parameter int    ADDR_WIDTH        = $clog2(SIZE),
  parameter string READ_DURING_WRITE = "NEW_DATA"
) (
  input  logic                  clk,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data
);

  localparam bit BYPASS = (READ_DURING_WRITE == "NEW_DATA");

  logic [DATA_WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[write_addr] <= write_data;
    end
    if (read_en) begin
      if (BYPASS && write_en && (write_addr == read_addr)) begin
        read_data <= write_data;
      end else begin
        read_data <= mem[read_addr];
      end
    end
  end

endmodule

// ============================================================================
// Module   : sram_access_arbiter
// Purpose  : Shares one sram_1r1w between NUM_REQUESTERS clients. After each
//            reset the whole array is swept to INIT_VALUE, then the read and
//            write ports are arbitrated independently with round-robin
//            priority. Read data returns one cycle after grant, tagged with
//            the id of the client that was granted.
// Ports    : clk, reset (async, active-high)
//            init_done                      1 once the init sweep is complete
//            rd_req / rd_addr / rd_grant    per-client read request/grant
//            rd_resp_valid/_id/_data        tagged read response
//            wr_req / wr_addr / wr_data / wr_grant   per-client write
// Revision : 1.0  initial release
// ============================================================================
module sram_access_arbiter #(
  parameter int                    NUM_REQUESTERS = 4,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    SIZE           = 1024,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  parameter int                    ADDR_WIDTH     = $clog2(SIZE),
  parameter int                    ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  output logic                                     init_done,
  input  logic [NUM_REQUESTERS-1:0]                rd_req,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQUESTERS-1:0]                rd_grant,
  output logic                                     rd_resp_valid,
  output logic [ID_WIDTH-1:0]                      rd_resp_id,
  output logic [DATA_WIDTH-1:0]                    rd_resp_data,
  input  logic [NUM_REQUESTERS-1:0]                wr_req,
  input  logic [NUM_REQUESTERS-1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQUESTERS-1:0][DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQUESTERS-1:0]                wr_grant
);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] init_addr, init_addr_next;
  logic                  init_done_next;
  logic [ID_WIDTH-1:0]   rd_ptr, rd_ptr_next, wr_ptr, wr_ptr_next;
  logic                  resp_valid_next;
  logic [ID_WIDTH-1:0]   resp_id_next;

  logic [ID_WIDTH:0]     rd_pick, wr_pick;   // {found, index}
  logic                  sram_re, sram_we;
  logic [ADDR_WIDTH-1:0] sram_raddr, sram_waddr;
  logic [DATA_WIDTH-1:0] sram_wdata;

  // First asserted request at or after ptr, wrapping modulo the client count.
  // The scan runs backwards so the closest match to ptr is the last one kept.
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [NUM_REQUESTERS-1:0] req,
    input logic [ID_WIDTH-1:0]       ptr
  );
    logic [ID_WIDTH:0] result;
    int                idx;
    result = '0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQUESTERS;
      if (req[idx]) begin
        result = {1'b1, idx[ID_WIDTH-1:0]};
      end
    end
    return result;
  endfunction

  function automatic logic [ID_WIDTH-1:0] ptr_after(input logic [ID_WIDTH-1:0] idx);
    return (idx == ID_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : idx + ID_WIDTH'(1);
  endfunction

  assign rd_pick = rr_pick(rd_req, rd_ptr);
  assign wr_pick = rr_pick(wr_req, wr_ptr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_INIT;
      init_addr     <= '0;
      init_done     <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      rd_resp_valid <= 1'b0;
      rd_resp_id    <= '0;
    end else begin
      state         <= state_next;
      init_addr     <= init_addr_next;
      init_done     <= init_done_next;
      rd_ptr        <= rd_ptr_next;
      wr_ptr        <= wr_ptr_next;
      rd_resp_valid <= resp_valid_next;
      rd_resp_id    <= resp_id_next;
    end
  end

  always_comb begin
    state_next      = state;
    init_addr_next  = init_addr;
    init_done_next  = init_done;
    rd_ptr_next     = rd_ptr;
    wr_ptr_next     = wr_ptr;
    resp_valid_next = 1'b0;
    resp_id_next    = rd_resp_id;
    rd_grant        = '0;
    wr_grant        = '0;
    sram_re         = 1'b0;
    sram_raddr      = rd_addr[rd_pick[ID_WIDTH-1:0]];
    sram_we         = 1'b0;
    sram_waddr      = init_addr;
    sram_wdata      = INIT_VALUE;

    case (state)
      ST_INIT: begin
        // Requests arriving now are simply not granted; clients keep them
        // asserted and win arbitration on the first RUN cycle.
        sram_we        = 1'b1;
        init_addr_next = init_addr + ADDR_WIDTH'(1);
        if (init_addr == ADDR_WIDTH'(SIZE - 1)) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_pick[ID_WIDTH]) begin
          rd_grant[rd_pick[ID_WIDTH-1:0]] = 1'b1;
          sram_re         = 1'b1;
          resp_valid_next = 1'b1;
          resp_id_next    = rd_pick[ID_WIDTH-1:0];
          rd_ptr_next     = ptr_after(rd_pick[ID_WIDTH-1:0]);
        end
        if (wr_pick[ID_WIDTH]) begin
          wr_grant[wr_pick[ID_WIDTH-1:0]] = 1'b1;
          sram_we     = 1'b1;
          sram_waddr  = wr_addr[wr_pick[ID_WIDTH-1:0]];
          sram_wdata  = wr_data[wr_pick[ID_WIDTH-1:0]];
          wr_ptr_next = ptr_after(wr_pick[ID_WIDTH-1:0]);
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  sram_1r1w #(
    .DATA_WIDTH        (DATA_WIDTH),
    .SIZE              (SIZE),
    .ADDR_WIDTH        (ADDR_WIDTH),
    .READ_DURING_WRITE ("NEW_DATA")
  ) u_sram (
    .clk        (clk),
    .read_en    (sram_re),
    .read_addr  (sram_raddr),
    .read_data  (rd_resp_data),
    .write_en   (sram_we),
    .write_addr (sram_waddr),
    .write_data (sram_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_access_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_access_arbiter
// Purpose  : Self-checking bench for sram_access_arbiter (N=4, SIZE=16).
//            A behavioural model checks every cycle; directed steps add
//            hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SZ = 16;
  localparam int AW = 4;
  localparam int IW = 2;
  localparam logic [DW-1:0] INITV = '0;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 init_done;
  logic [N-1:0]         rd_req, rd_grant, wr_req, wr_grant;
  logic [N-1:0][AW-1:0] rd_addr, wr_addr;
  logic [N-1:0][DW-1:0] wr_data;
  logic                 rd_resp_valid;
  logic [IW-1:0]        rd_resp_id;
  logic [DW-1:0]        rd_resp_data;

  int vectors = 0;
  int miscompares = 0;

  sram_access_arbiter #(
    .NUM_REQUESTERS (N),
    .DATA_WIDTH     (DW),
    .SIZE           (SZ),
    .INIT_VALUE     (INITV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init_done     (init_done),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_grant      (rd_grant),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_id    (rd_resp_id),
    .rd_resp_data  (rd_resp_data),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_grant      (wr_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_init_cnt = 0;
  int            m_rd_ptr = 0;
  int            m_wr_ptr = 0;
  logic [DW-1:0] m_mem [SZ];
  logic          m_pend_valid = 1'b0;
  int            m_pend_id = 0;
  logic [DW-1:0] m_pend_data = '0;

  // Round-robin: the nearest requesting client at or after ptr.
  function automatic int rr_choose(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int r, w;
    logic [N-1:0] eg_r, eg_w;
    if (reset) begin
      m_init_cnt   = 0;
      m_rd_ptr     = 0;
      m_wr_ptr     = 0;
      m_pend_valid = 1'b0;
      check("rst_init_done", init_done, 0);
      check("rst_resp_valid", rd_resp_valid, 0);
      check("rst_resp_id", rd_resp_id, 0);
      check("rst_grants", {rd_grant, wr_grant}, 0);
    end else begin
      check("resp_valid", rd_resp_valid, m_pend_valid);
      if (m_pend_valid) begin
        check("resp_id", rd_resp_id, m_pend_id);
        check("resp_data", rd_resp_data, m_pend_data);
      end
      m_pend_valid = 1'b0;
      if (m_init_cnt < SZ) begin
        check("init_done_low", init_done, 0);
        check("init_grants", {rd_grant, wr_grant}, 0);
        m_mem[m_init_cnt] = INITV;
        m_init_cnt++;
      end else begin
        check("init_done_high", init_done, 1);
        r = rr_choose(rd_req, m_rd_ptr);
        w = rr_choose(wr_req, m_wr_ptr);
        eg_r = (r >= 0) ? N'(1 << r) : '0;
        eg_w = (w >= 0) ? N'(1 << w) : '0;
        check("rd_grant", rd_grant, eg_r);
        check("wr_grant", wr_grant, eg_w);
        if (r >= 0) begin
          m_pend_valid = 1'b1;
          m_pend_id    = r;
          if (w >= 0 && wr_addr[w] == rd_addr[r]) m_pend_data = wr_data[w];
          else                                    m_pend_data = m_mem[rd_addr[r]];
          m_rd_ptr = (r + 1) % N;
        end
        if (w >= 0) begin
          m_mem[wr_addr[w]] = wr_data[w];
          m_wr_ptr = (w + 1) % N;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [N-1:0] t2_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [IW-1:0] t2_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [N-1:0] t5_grant [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input string name);
    for (int k = 1; k <= SZ; k++) begin
      tick();
      check(name, init_done, (k == SZ));
    end
  endtask

  initial begin
    rd_req = '0; wr_req = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    reset = 1'b1;
    repeat (3) tick();

    // 1. init sweep, a request held from INIT, then read every entry
    reset = 1'b0;
    for (int k = 1; k <= SZ; k++) begin
      if (k == 10) begin rd_req = 4'b1000; rd_addr[3] = 4'd9; end
      tick();
      check("t1_init_done", init_done, (k == SZ));
    end
    #1 check("t1_held_grant", rd_grant, 4'b1000);
    tick();
    rd_req = '0;
    check("t1_held_resp", {rd_resp_valid, rd_resp_id}, {1'b1, 2'd3});
    for (int a = 0; a < SZ; a++) begin
      rd_req = 4'b0001; rd_addr[0] = a[AW-1:0];
      tick();
    end
    rd_req = '0;
    check("t1_last_read", {rd_resp_valid, rd_resp_data}, {1'b1, INITV});

    // 2. all readers requesting; first park rd_ptr at 0
    rd_req = 4'b1000; tick();
    rd_req = 4'b1111; rd_addr = {4'd3, 4'd2, 4'd1, 4'd0};
    for (int i = 0; i < 5; i++) begin
      #1 check("t2_rd_grant", rd_grant, t2_grant[i]);
      tick();
      check("t2_resp_id", {rd_resp_valid, rd_resp_id}, {1'b1, t2_id[i]});
    end

    // 3. sparse fairness (rd_ptr is 1 here)
    rd_req = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 check("t3_alternate", rd_grant, (i % 2 == 0) ? 4'b0010 : 4'b1000);
      tick();
    end
    rd_req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_single", rd_grant, 4'b1000);
      tick();
    end

    // 4. same-cycle write/read of one address returns the new data
    rd_req = 4'b0100; rd_addr[2] = 4'd5;
    wr_req = 4'b0001; wr_addr[0] = 4'd5; wr_data[0] = 32'hDEADBEEF;
    #1 check("t4_grants", {rd_grant, wr_grant}, {4'b0100, 4'b0001});
    tick();
    rd_req = '0; wr_req = '0;
    check("t4_bypass", {rd_resp_valid, rd_resp_id, rd_resp_data}, {1'b1, 2'd2, 32'hDEADBEEF});

    // 5. independence; park wr_ptr at 0 first
    wr_req = 4'b1000; wr_addr[3] = 4'd0; wr_data[3] = 32'h0000_00AA; tick();
    wr_req = 4'b1111; rd_req = 4'b0001; rd_addr[0] = 4'd8;
    for (int i = 0; i < N; i++) begin
      wr_addr[i] = AW'(8 + i);
      wr_data[i] = 32'h1111_1111 * i + 1;
    end
    for (int i = 0; i < 4; i++) begin
      #1 check("t5_grants", {rd_grant, wr_grant}, {4'b0001, t5_grant[i]});
      tick();
    end
    wr_req = '0;
    for (int a = 8; a < 12; a++) begin
      rd_req = 4'b0010; rd_addr[1] = a[AW-1:0];
      tick();
    end
    rd_req = '0;
    check("t5_readback", {rd_resp_valid, rd_resp_id, rd_resp_data}, {1'b1, 2'd1, 32'h3333_3334});

    // 6. reset during the sweep, then reset right after a read grant
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (7) tick();
    reset = 1'b1;
    #1 check("t6_mid_init_done", init_done, 0);
    tick(); reset = 1'b0;
    sweep_check("t6_sweep1");
    rd_req = 4'b0001; rd_addr[0] = 4'd5;
    tick();
    reset = 1'b1; rd_req = '0;
    #1 check("t6_resp_dropped", {rd_resp_valid, init_done}, 2'b00);
    tick(); reset = 1'b0;
    sweep_check("t6_sweep2");
    rd_req = 4'b0001; rd_addr[0] = 4'd5;
    tick();
    rd_req = '0;
    check("t6_reinit_data", {rd_resp_valid, rd_resp_data}, {1'b1, INITV});

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
